// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I widths, opcodes, immediate formats, ALU ops and controller states
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [6:0] OP_LOAD     = 7'h03;
  localparam logic [6:0] OP_MISC_MEM = 7'h0F;
  localparam logic [6:0] OP_IMM      = 7'h13;
  localparam logic [6:0] OP_AUIPC    = 7'h17;
  localparam logic [6:0] OP_STORE    = 7'h23;
  localparam logic [6:0] OP_OP       = 7'h33;
  localparam logic [6:0] OP_LUI      = 7'h37;
  localparam logic [6:0] OP_BRANCH   = 7'h63;
  localparam logic [6:0] OP_JALR     = 7'h67;
  localparam logic [6:0] OP_JAL      = 7'h6F;
  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADR, S_MEM_RD, S_MEM_WB,
    S_MEM_WR, S_ALU_WB, S_BRANCH, S_JAL, S_JALR_ADR, S_JALR, S_LUI_WB
  } ctrl_state_e;
endpackage

// File: rtl/control_unit_alu_decoder.sv
// alu_decoder: maps R-type / OP-IMM funct fields onto an ALU operation
module alu_decoder
  import riscv_pkg::*;
(
  input  logic       is_rtype_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  output alu_op_e    op_o
);
  // funct7[5] means SUB only for R-type; for shifts it selects SRA in both forms
  always_comb begin
    op_o = ALU_ADD;
    case (funct3_i)
      3'd0: op_o = (is_rtype_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
      3'd1: op_o = ALU_SLL;
      3'd2: op_o = ALU_SLT;
      3'd3: op_o = ALU_SLTU;
      3'd4: op_o = ALU_XOR;
      3'd5: op_o = funct7b5_i ? ALU_SRA : ALU_SRL;
      3'd6: op_o = ALU_OR;
      default: op_o = ALU_AND;
    endcase
  end
endmodule

// File: rtl/control_unit.sv
// control_unit: multicycle RV32I Moore controller driving datapath enables and mux selects
module control_unit
  import riscv_pkg::*;
(
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic [XLEN-1:0] Instr_i,
  input  logic            Branch_i,
  output logic            PCWrite_o,
  output logic            MemWrite_o,
  output logic            IRWrite_o,
  output logic            RegWrite_o,
  output logic [2:0]      ImmSrc_o,
  output logic [1:0]      ALUSrcA_o,
  output logic [1:0]      ALUSrcB_o,
  output alu_op_e         ALUControl_o,
  output logic [1:0]      ResultSrc_o,
  output logic            B_EN_o,
  output logic            Retired_o,
  output logic            Illegal_o
);
  ctrl_state_e state_q, state_d;
  alu_op_e     dec_op;
  logic [6:0]  opcode;
  logic        unused_instr;
  assign opcode       = Instr_i[6:0];
  assign unused_instr = ^{Instr_i[31], Instr_i[29:15], Instr_i[11:7]};
  alu_decoder u_alu_dec (
    .is_rtype_i (opcode == OP_OP),
    .funct3_i   (Instr_i[14:12]),
    .funct7b5_i (Instr_i[30]),
    .op_o       (dec_op)
  );
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = S_DECODE;
      S_DECODE:
        case (opcode)
          OP_OP:             state_d = S_EXEC_R;
          OP_IMM:            state_d = S_EXEC_I;
          OP_LOAD, OP_STORE: state_d = S_MEM_ADR;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR_ADR;
          OP_LUI:            state_d = S_LUI_WB;
          OP_AUIPC:          state_d = S_ALU_WB;
          default:           state_d = S_FETCH;
        endcase
      S_EXEC_R, S_EXEC_I, S_JAL, S_JALR: state_d = S_ALU_WB;
      S_MEM_ADR:  state_d = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   state_d = S_MEM_WB;
      S_JALR_ADR: state_d = S_JALR;
      default:    state_d = S_FETCH;
    endcase
  end
  always_ff @(posedge clk_i or negedge rstn_i)
    if (!rstn_i) state_q <= S_FETCH;
    else         state_q <= state_d;
  always_comb begin
    PCWrite_o    = 1'b0;
    MemWrite_o   = 1'b0;
    IRWrite_o    = 1'b0;
    RegWrite_o   = 1'b0;
    ImmSrc_o     = IMM_I;
    ALUSrcA_o    = 2'd0;
    ALUSrcB_o    = 2'd0;
    ALUControl_o = ALU_ADD;
    ResultSrc_o  = 2'd0;
    B_EN_o       = 1'b0;
    Retired_o    = 1'b0;
    Illegal_o    = 1'b0;
    case (state_q)
      S_FETCH: begin
        ALUSrcB_o   = 2'd2;
        ResultSrc_o = 2'd1;
        PCWrite_o   = 1'b1;
        IRWrite_o   = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA_o = 2'd1;
        ALUSrcB_o = 2'd1;
        ImmSrc_o  = (opcode == OP_BRANCH) ? IMM_B :
                    (opcode == OP_JAL)    ? IMM_J :
                    (opcode == OP_AUIPC)  ? IMM_U : IMM_I;
        Retired_o = (opcode == OP_MISC_MEM);
        Illegal_o = !(opcode inside {OP_OP, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
                                     OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_MISC_MEM});
      end
      S_EXEC_R: begin
        ALUSrcA_o    = 2'd2;
        ALUControl_o = dec_op;
      end
      S_EXEC_I: begin
        ALUSrcA_o    = 2'd2;
        ALUSrcB_o    = 2'd1;
        ALUControl_o = dec_op;
      end
      S_MEM_ADR: begin
        ALUSrcA_o = 2'd2;
        ALUSrcB_o = 2'd1;
        ImmSrc_o  = (opcode == OP_STORE) ? IMM_S : IMM_I;
      end
      S_MEM_WB: begin
        ResultSrc_o = 2'd3;
        RegWrite_o  = 1'b1;
        Retired_o   = 1'b1;
      end
      S_MEM_WR: begin
        MemWrite_o = 1'b1;
        Retired_o  = 1'b1;
      end
      S_ALU_WB: begin
        RegWrite_o = 1'b1;
        Retired_o  = 1'b1;
      end
      S_BRANCH: begin
        B_EN_o    = 1'b1;
        PCWrite_o = Branch_i;
        Retired_o = 1'b1;
      end
      S_JAL, S_JALR: begin
        PCWrite_o = 1'b1;
        ALUSrcA_o = 2'd1;
        ALUSrcB_o = 2'd2;
      end
      S_JALR_ADR: begin
        ALUSrcA_o = 2'd2;
        ALUSrcB_o = 2'd1;
      end
      S_LUI_WB: begin
        ImmSrc_o    = IMM_U;
        ResultSrc_o = 2'd2;
        RegWrite_o  = 1'b1;
        Retired_o   = 1'b1;
      end
      default: ;
    endcase
    // reset overrides the FETCH decode so nothing is written while held
    if (!rstn_i) begin
      PCWrite_o    = 1'b0;
      IRWrite_o    = 1'b0;
      ALUSrcB_o    = 2'd0;
      ResultSrc_o  = 2'd0;
      MemWrite_o   = 1'b0;
      RegWrite_o   = 1'b0;
      ImmSrc_o     = IMM_I;
      ALUSrcA_o    = 2'd0;
      ALUControl_o = ALU_ADD;
      B_EN_o       = 1'b0;
      Retired_o    = 1'b0;
      Illegal_o    = 1'b0;
    end
  end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed per-instruction cycle checks of the multicycle controller outputs
module tb_control_unit;
  import riscv_pkg::*;
  typedef logic [19:0] cv_t;
  logic        clk = 1'b0;
  logic        rstn_i;
  logic [31:0] Instr_i;
  logic        Branch_i;
  logic        PCWrite_o, MemWrite_o, IRWrite_o, RegWrite_o, B_EN_o, Retired_o, Illegal_o;
  logic [2:0]  ImmSrc_o;
  logic [1:0]  ALUSrcA_o, ALUSrcB_o, ResultSrc_o;
  alu_op_e     ALUControl_o;
  cv_t         ctl;
  int          total = 0;
  int          bad = 0;
  always #5 clk = ~clk;
  control_unit dut (
    .clk_i(clk), .rstn_i(rstn_i), .Instr_i(Instr_i), .Branch_i(Branch_i),
    .PCWrite_o(PCWrite_o), .MemWrite_o(MemWrite_o), .IRWrite_o(IRWrite_o),
    .RegWrite_o(RegWrite_o), .ImmSrc_o(ImmSrc_o), .ALUSrcA_o(ALUSrcA_o),
    .ALUSrcB_o(ALUSrcB_o), .ALUControl_o(ALUControl_o), .ResultSrc_o(ResultSrc_o),
    .B_EN_o(B_EN_o), .Retired_o(Retired_o), .Illegal_o(Illegal_o)
  );
  assign ctl = {PCWrite_o, MemWrite_o, IRWrite_o, RegWrite_o, ImmSrc_o, ALUSrcA_o,
                ALUSrcB_o, ALUControl_o, ResultSrc_o, B_EN_o, Retired_o, Illegal_o};
  // field order: pcw mw irw rw imm a b alu rs ben ret ill
  function automatic cv_t cv(input logic pcw, mw, irw, rw, input logic [2:0] imm,
                             input logic [1:0] a, b, input alu_op_e op,
                             input logic [1:0] rs, input logic ben, ret, ill);
    return {pcw, mw, irw, rw, imm, a, b, op, rs, ben, ret, ill};
  endfunction
  function automatic cv_t v_f();                 return cv(1,0,1,0,IMM_I,0,2,ALU_ADD,1,0,0,0); endfunction
  function automatic cv_t v_d(input logic [2:0] i); return cv(0,0,0,0,i,1,1,ALU_ADD,0,0,0,0); endfunction
  function automatic cv_t v_xr(input alu_op_e o); return cv(0,0,0,0,IMM_I,2,0,o,0,0,0,0); endfunction
  function automatic cv_t v_xi(input alu_op_e o); return cv(0,0,0,0,IMM_I,2,1,o,0,0,0,0); endfunction
  function automatic cv_t v_ma(input logic [2:0] i); return cv(0,0,0,0,i,2,1,ALU_ADD,0,0,0,0); endfunction
  function automatic cv_t v_awb();               return cv(0,0,0,1,IMM_I,0,0,ALU_ADD,0,0,1,0); endfunction
  function automatic cv_t v_mwb();               return cv(0,0,0,1,IMM_I,0,0,ALU_ADD,3,0,1,0); endfunction
  function automatic cv_t v_mwr();               return cv(0,1,0,0,IMM_I,0,0,ALU_ADD,0,0,1,0); endfunction
  function automatic cv_t v_br(input logic t);   return cv(t,0,0,0,IMM_I,0,0,ALU_ADD,0,1,1,0); endfunction
  function automatic cv_t v_j();                 return cv(1,0,0,0,IMM_I,1,2,ALU_ADD,0,0,0,0); endfunction
  function automatic cv_t v_lui();               return cv(0,0,0,1,IMM_U,0,0,ALU_ADD,2,0,1,0); endfunction

  task automatic test_reset();
    rstn_i = 1'b0; Instr_i = 32'h0; Branch_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (ctl !== 20'h0) begin bad++; $display("FAIL reset_hold got=%h exp=%h", ctl, 20'h0); end
    rstn_i = 1'b1;
    Branch_i = 1'b0;
  endtask

  task automatic test_rtype();
    cv_t ex[$];
    logic [31:0] ins [3] = '{32'h002081B3, 32'h402081B3, 32'h4020D1B3};
    alu_op_e     ops [3] = '{ALU_ADD, ALU_SUB, ALU_SRA};
    for (int k = 0; k < 3; k++) begin
      Instr_i = ins[k];
      ex = {v_f(), v_d(IMM_I), v_xr(ops[k]), v_awb()};
      foreach (ex[i]) begin
        @(negedge clk); total++;
        if (ctl !== ex[i]) begin bad++; $display("FAIL rtype%0d cyc%0d got=%h exp=%h", k, i, ctl, ex[i]); end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_itype();
    cv_t ex[$];
    logic [31:0] ins [4] = '{32'hC0000093, 32'h4030D093, 32'h00309093, 32'h0050F093};
    alu_op_e     ops [4] = '{ALU_ADD, ALU_SRA, ALU_SLL, ALU_AND};
    for (int k = 0; k < 4; k++) begin
      Instr_i = ins[k];
      ex = {v_f(), v_d(IMM_I), v_xi(ops[k]), v_awb()};
      foreach (ex[i]) begin
        @(negedge clk); total++;
        if (ctl !== ex[i]) begin bad++; $display("FAIL itype%0d cyc%0d got=%h exp=%h", k, i, ctl, ex[i]); end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_branch();
    cv_t ex[$];
    Instr_i = 32'h00108863;
    for (int t = 1; t >= 0; t--) begin
      Branch_i = t[0];
      ex = {v_f(), v_d(IMM_B), v_br(t[0])};
      foreach (ex[i]) begin
        @(negedge clk); total++;
        if (ctl !== ex[i]) begin bad++; $display("FAIL branch_t%0d cyc%0d got=%h exp=%h", t, i, ctl, ex[i]); end
        if (i < 2) begin @(posedge clk); #1; end
      end
      Branch_i = ~t[0];
      #1; total++;
      if (PCWrite_o !== ~t[0]) begin bad++; $display("FAIL branch_comb got=%b exp=%b", PCWrite_o, ~t[0]); end
      @(posedge clk); #1;
    end
    Branch_i = 1'b0;
  endtask

  task automatic test_load_store();
    cv_t ex[$];
    Instr_i = 32'h00402203;
    ex = {v_f(), v_d(IMM_I), v_ma(IMM_I), 20'h0, v_mwb()};
    foreach (ex[i]) begin
      @(negedge clk); total++;
      if (ctl !== ex[i]) begin bad++; $display("FAIL load cyc%0d got=%h exp=%h", i, ctl, ex[i]); end
      @(posedge clk); #1;
    end
    Instr_i = 32'h00402423;
    ex = {v_f(), v_d(IMM_I), v_ma(IMM_S), v_mwr()};
    foreach (ex[i]) begin
      @(negedge clk); total++;
      if (ctl !== ex[i]) begin bad++; $display("FAIL store cyc%0d got=%h exp=%h", i, ctl, ex[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_jumps();
    cv_t ex[$];
    Instr_i = 32'h020000EF;
    ex = {v_f(), v_d(IMM_J), v_j(), v_awb()};
    foreach (ex[i]) begin
      @(negedge clk); total++;
      if (ctl !== ex[i]) begin bad++; $display("FAIL jal cyc%0d got=%h exp=%h", i, ctl, ex[i]); end
      @(posedge clk); #1;
    end
    Instr_i = 32'h00008067;
    ex = {v_f(), v_d(IMM_I), v_ma(IMM_I), v_j(), v_awb()};
    foreach (ex[i]) begin
      @(negedge clk); total++;
      if (ctl !== ex[i]) begin bad++; $display("FAIL jalr cyc%0d got=%h exp=%h", i, ctl, ex[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_upper();
    cv_t ex[$];
    Instr_i = 32'h123452B7;
    ex = {v_f(), v_d(IMM_I), v_lui()};
    foreach (ex[i]) begin
      @(negedge clk); total++;
      if (ctl !== ex[i]) begin bad++; $display("FAIL lui cyc%0d got=%h exp=%h", i, ctl, ex[i]); end
      @(posedge clk); #1;
    end
    Instr_i = 32'h00001297;
    ex = {v_f(), v_d(IMM_U), v_awb()};
    foreach (ex[i]) begin
      @(negedge clk); total++;
      if (ctl !== ex[i]) begin bad++; $display("FAIL auipc cyc%0d got=%h exp=%h", i, ctl, ex[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_fence_illegal();
    cv_t ex[$];
    Instr_i = 32'h0FF0000F;
    ex = {v_f(), cv(0,0,0,0,IMM_I,1,1,ALU_ADD,0,0,1,0)};
    foreach (ex[i]) begin
      @(negedge clk); total++;
      if (ctl !== ex[i]) begin bad++; $display("FAIL fence cyc%0d got=%h exp=%h", i, ctl, ex[i]); end
      @(posedge clk); #1;
    end
    Instr_i = 32'h0000007F;
    ex = {v_f(), cv(0,0,0,0,IMM_I,1,1,ALU_ADD,0,0,0,1), v_f()};
    foreach (ex[i]) begin
      @(negedge clk); total++;
      if (ctl !== ex[i]) begin bad++; $display("FAIL illegal cyc%0d got=%h exp=%h", i, ctl, ex[i]); end
      if (i < 2) begin @(posedge clk); #1; end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset();
    cv_t ex[$];
    Instr_i = 32'h00402203;
    ex = {v_d(IMM_I), v_ma(IMM_I)};
    foreach (ex[i]) begin
      @(negedge clk); total++;
      if (ctl !== ex[i]) begin bad++; $display("FAIL midrst_pre cyc%0d got=%h exp=%h", i, ctl, ex[i]); end
      if (i < 1) begin @(posedge clk); #1; end
    end
    #1 rstn_i = 1'b0;
    #1; total++;
    if (ctl !== 20'h0) begin bad++; $display("FAIL midrst_immediate got=%h exp=%h", ctl, 20'h0); end
    @(posedge clk); #1; total++;
    if (ctl !== 20'h0) begin bad++; $display("FAIL midrst_held got=%h exp=%h", ctl, 20'h0); end
    rstn_i = 1'b1;
    ex = {v_f(), v_d(IMM_I), v_ma(IMM_I)};
    foreach (ex[i]) begin
      @(negedge clk); total++;
      if (ctl !== ex[i]) begin bad++; $display("FAIL midrst_post cyc%0d got=%h exp=%h", i, ctl, ex[i]); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_itype();
    test_branch();
    test_load_store();
    test_jumps();
    test_upper();
    test_fence_illegal();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
